// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with configurable data width, parity and stop bits.
// A small write FIFO feeds a start/data/parity/stop FSM; queued frames go out back-to-back.
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic                          tx_start,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic                          tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic              ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 push, pop, empty;
  logic [DATA_BITS-1:0] head;

  assign tx_full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign push       = tx_start && !tx_full;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  // NOTE: the storage array has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // ----------------------------------------------------------------- FSM
  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_serial_q, tx_serial_d;
  logic                 bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  // NOTE: combinational blocks use blocking '=' with every output defaulted first,
  // so no latch is inferred; only the always_ff blocks use '<='.
  always_comb begin
    state_d   = state_q;
    baud_d    = bit_end ? '0 : baud_q + BAUD_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop       = 1'b0;
    tx_done   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (^head) ^ ODD_PAR;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_idx_q == STOP_LAST) begin
            tx_done   = 1'b1;
            bit_idx_d = '0;
            // A waiting word starts its frame on this edge, so frames abut.
            if (!empty) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = (^head) ^ ODD_PAR;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the next state so the registered output lines up with the state.
    unique case (state_d)
      S_START:  tx_serial_d = 1'b0;
      S_DATA:   tx_serial_d = shift_d[0];
      S_PARITY: tx_serial_d = par_d;
      default:  tx_serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tx_serial_q <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tx_serial_q <= tx_serial_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign tx_serial = tx_serial_q;
  assign tx_busy   = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus queues expected words, per-instance
// monitors decode each serial frame and compare it against the queue front.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic [4:0] st = '0;
  logic [7:0] din = '0;
  logic [4:0] ser, busy, done, full;
  logic [2:0] cnt [5];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    int         idx;
    logic [8:0] data;
    bit         b2b;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u0: 8N1, u1: 8E1, u2: 8O1, u3: 7N2 (all 16 clocks/bit), u4: defaults (434 clocks/bit)
  uart_tx_cfg #(.CLK_FREQ(16), .BAUD_RATE(1)) u0 (
    .clk(clk), .rst_(rst_), .tx_start(st[0]), .tx_data(din),
    .tx_full(full[0]), .fifo_count(cnt[0]), .tx_serial(ser[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_cfg #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(1)) u1 (
    .clk(clk), .rst_(rst_), .tx_start(st[1]), .tx_data(din),
    .tx_full(full[1]), .fifo_count(cnt[1]), .tx_serial(ser[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_cfg #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(2)) u2 (
    .clk(clk), .rst_(rst_), .tx_start(st[2]), .tx_data(din),
    .tx_full(full[2]), .fifo_count(cnt[2]), .tx_serial(ser[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_cfg #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(7), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_(rst_), .tx_start(st[3]), .tx_data(din[6:0]),
    .tx_full(full[3]), .fifo_count(cnt[3]), .tx_serial(ser[3]), .tx_busy(busy[3]), .tx_done(done[3]));
  uart_tx_cfg u4 (
    .clk(clk), .rst_(rst_), .tx_start(st[4]), .tx_data(din),
    .tx_full(full[4]), .fifo_count(cnt[4]), .tx_serial(ser[4]), .tx_busy(busy[4]), .tx_done(done[4]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decodes one frame per start bit, sampling at negedge; aborts silently on reset.
  task automatic monitor(input int i, input int dbits, input int par, input int stops, input int cpb);
    int         nb, shape_err, done_err, k, last_end;
    logic [8:0] exp_d, rx;
    logic       lvl, pbit, rx_par;
    bit         b2b, aborted;
    last_end = -100;
    forever begin
      @(negedge clk);
      if (rst_ || ser[i]) continue;
      if (sb.size() == 0 || sb[0].idx != i) begin
        check($sformatf("unexpected_frame_u%0d", i), 1, 0);
        while (ser[i] == 1'b0 && !rst_) @(negedge clk);
        continue;
      end
      exp_d = sb[0].data & 9'((1 << dbits) - 1);
      b2b   = sb[0].b2b;
      pbit  = (^exp_d) ^ (par == 2);
      if (b2b) check($sformatf("b2b_gap_u%0d", i), cyc - last_end, 1);
      nb = 1 + dbits + ((par != 0) ? 1 : 0) + stops;
      shape_err = 0; done_err = 0; rx = '0; rx_par = 1'bx; aborted = 0;
      for (int c = 0; c < nb * cpb; c++) begin
        if (c > 0) @(negedge clk);
        if (rst_) begin aborted = 1; break; end
        k = c / cpb;
        if (k == 0)                          lvl = 1'b0;
        else if (k <= dbits)                 lvl = exp_d[k-1];
        else if (par != 0 && k == dbits + 1) lvl = pbit;
        else                                 lvl = 1'b1;
        if (ser[i] !== lvl) shape_err++;
        if (done[i] !== (c == nb * cpb - 1)) done_err++;
        if (c % cpb == cpb / 2) begin
          if (k >= 1 && k <= dbits) rx[k-1] = ser[i];
          if (par != 0 && k == dbits + 1) rx_par = ser[i];
        end
      end
      if (aborted) continue;
      last_end = cyc;
      void'(sb.pop_front());
      check($sformatf("data_u%0d", i), rx, exp_d);
      if (par != 0) check($sformatf("parity_u%0d", i), rx_par, pbit);
      check($sformatf("bit_timing_u%0d", i), shape_err, 0);
      check($sformatf("done_pulse_u%0d", i), done_err, 0);
    end
  endtask

  // Caller sits at a negedge; the write is sampled at the following posedge.
  task automatic push(input int i, input logic [8:0] d, input bit b2b);
    exp_t e;
    e.idx = i; e.data = d; e.b2b = b2b;
    sb.push_back(e);
    st[i] = 1'b1;
    din   = d[7:0];
    @(negedge clk);
    st[i] = 1'b0;
  endtask

  task automatic wait_frames(input int i, input int n, input int budget, input bit chk_idle);
    int got = 0;
    int t = 0;
    while (got < n && t < budget) begin
      @(negedge clk);
      t++;
      if (done[i]) got++;
    end
    check($sformatf("done_count_u%0d", i), got, n);
    if (chk_idle) begin
      @(negedge clk);
      check($sformatf("busy_fall_u%0d", i), busy[i], 0);
      check($sformatf("sb_drained_u%0d", i), sb.size(), 0);
    end
  endtask

  initial begin
    fork
      monitor(0, 8, 0, 1, 16);
      monitor(1, 8, 1, 1, 16);
      monitor(2, 8, 2, 1, 16);
      monitor(3, 7, 0, 2, 16);
      monitor(4, 8, 0, 1, 434);
    join_none
  end

  initial begin
    #2_000_000;
    check("watchdog_timeout", 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_serial", ser[0], 1);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_full", full[0], 0);
    check("rst_count", cnt[0], 0);

    // 8N1 single word, written on the first edge after reset release
    rst_ = 1'b0;
    sb.push_back('{0, 9'h0A5, 1'b0});
    st[0] = 1'b1; din = 8'hA5;
    @(negedge clk);
    st[0] = 1'b0; din = 8'hFF;
    check("lat_count_e0", cnt[0], 1);
    check("lat_busy_e0", busy[0], 1);
    check("lat_serial_e0", ser[0], 1);
    @(negedge clk);
    check("lat_count_e1", cnt[0], 0);
    check("lat_serial_e1", ser[0], 0);
    wait_frames(0, 1, 200, 1'b1);

    // Parity modes and 7N2
    push(1, 9'h007, 1'b0);
    wait_frames(1, 1, 200, 1'b1);
    push(2, 9'h007, 1'b0);
    wait_frames(2, 1, 200, 1'b1);
    push(3, 9'h041, 1'b0);
    wait_frames(3, 1, 200, 1'b1);

    // FIFO full: six back-to-back writes, the sixth is dropped
    for (int j = 0; j < 6; j++) begin
      if (j < 5) sb.push_back('{0, 9'(8'h10 + j), (j > 0)});
      st[0] = 1'b1;
      din   = 8'h10 + 8'(j);
      @(negedge clk);
      if (j == 3) check("not_full_after_4th", full[0], 0);
      if (j == 4) check("full_after_5th", full[0], 1);
    end
    st[0] = 1'b0;
    check("count_after_drop", cnt[0], 4);
    wait_frames(0, 5, 900, 1'b1);

    // Reset during data bit 3 of the second queued frame
    push(0, 9'h033, 1'b0);
    push(0, 9'h0CC, 1'b1);
    push(0, 9'h05A, 1'b1);
    wait_frames(0, 1, 200, 1'b0);
    repeat (69) @(negedge clk);
    check("count_before_rst", cnt[0], 1);
    check("busy_before_rst", busy[0], 1);
    #2 rst_ = 1'b1;
    #1;
    check("async_rst_serial", ser[0], 1);
    check("async_rst_busy", busy[0], 0);
    check("async_rst_count", cnt[0], 0);
    check("async_rst_done", done[0], 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_ = 1'b0;
    @(negedge clk);
    check("post_rst_idle", busy[0], 0);
    push(0, 9'h096, 1'b0);
    wait_frames(0, 1, 200, 1'b1);

    // Default parameters: 434 clocks per bit, 4340-cycle frame
    push(4, 9'h03C, 1'b0);
    wait_frames(4, 1, 5000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
